// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared types and constants for the S-box scheduler slice.
//   WORD_W / BLOCK_W / NUM_WORDS : datapath geometry for AES-128.
//   sched_state_e                : scheduler FSM encoding.
//   gf_mul / gf_inv / sbox_byte  : GF(2^8) helpers behind the S-box word.
package aes_sched_pkg;

  localparam int WORD_W    = 32;
  localparam int BLOCK_W   = 128;
  localparam int NUM_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  typedef logic [31:0] aes_word_t;

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1 (shift-and-add).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ x;
      end else begin
        p = p;
      end
      x = {x[6:0], 1'b0} ^ ({8{x[7]}} & 8'h1B);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] acc;
    logic [7:0] sq;
    acc = 8'h01;
    sq  = a;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Forward AES S-box: inverse followed by the affine transform.
  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sbox_rr_arb.sv
// aes_sbox_rr_arb: two-requester round-robin arbiter for the shared S-box.
//   clk, rst_n  : clock, async active-low reset
//   req_st_i    : state-word requester (only asserted while serialising)
//   req_kx_i    : key-expansion requester
//   force_kx_i  : outside RUN the S-box is free, so kx always wins and the
//                 pointer is reloaded to KEY_PRIO for the next block
//   gnt_kx_o / gnt_st_o : grants
module aes_sbox_rr_arb #(
  parameter bit KEY_PRIO = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_st_i,
  input  logic req_kx_i,
  input  logic force_kx_i,
  output logic gnt_kx_o,
  output logic gnt_st_o
);

  // ptr_q = 1 means kx wins the next tie.
  logic ptr_q;
  logic ptr_d;

  // Grant decode and pointer next state; pointer flips to the loser on a tie.
  always_comb begin
    gnt_kx_o = req_kx_i & (force_kx_i | ~req_st_i | ptr_q);
    gnt_st_o = req_st_i & ~gnt_kx_o;
    if (force_kx_i) begin
      ptr_d = KEY_PRIO;
    end else if (req_st_i && req_kx_i) begin
      ptr_d = ~ptr_q;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= KEY_PRIO;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/aes_sbox_word.sv
// aes_sbox_word: four parallel forward AES S-boxes (SubWord), combinational.
//   word_i : 32-bit input word
//   word_o : byte-wise substituted word
module aes_sbox_word
  import aes_sched_pkg::*;
(
  input  aes_word_t word_i,
  output aes_word_t word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_o[8*b +: 8] = sbox_byte(word_i[8*b +: 8]);
  end

endmodule

// File: rtl/aes_sbox_sched.sv
// aes_sbox_sched: time-shares one aes_sbox_word between SubBytes over a
// 128-bit state (serialised as four words) and key-expansion SubWord.
//   st_req_*  : state request (accepted only in IDLE)
//   st_rsp_*  : substituted state, held in DONE until st_rsp_ready
//   kx_req_*  : SubWord request; kx_req_ready is the same-cycle grant
//   kx_rsp_*  : one-cycle result pulse, data held until the next result
//   busy      : FSM not in IDLE
//   perf_stall_cnt : denied-requester cycle counter when the macro
//                    AES_SBOX_SCHED_PERF_EN is defined, otherwise 0
module aes_sbox_sched
  import aes_sched_pkg::*;
#(
  parameter bit KEY_PRIO = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_req_data,
  output logic         st_rsp_valid,
  input  logic         st_rsp_ready,
  output logic [127:0] st_rsp_data,
  input  logic         kx_req_valid,
  output logic         kx_req_ready,
  input  logic [31:0]  kx_req_data,
  output logic         kx_rsp_valid,
  output logic [31:0]  kx_rsp_data,
  output logic         busy,
  output logic [15:0]  perf_stall_cnt
);

  sched_state_e                           state_q, state_d;
  logic [1:0]                             idx_q, idx_d;
  logic [NUM_WORDS-1:0][WORD_W-1:0]       buf_q, buf_d;
  logic                                   kx_rsp_valid_q, kx_rsp_valid_d;
  aes_word_t                              kx_rsp_data_q, kx_rsp_data_d;

  logic      req_st_s;
  logic      force_kx_s;
  logic      gnt_kx_s;
  logic      gnt_st_s;
  aes_word_t sbox_in_s;
  aes_word_t sbox_out_s;

  assign req_st_s   = (state_q == RUN);
  assign force_kx_s = (state_q != RUN);

  aes_sbox_rr_arb #(.KEY_PRIO(KEY_PRIO)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_st_i   (req_st_s),
    .req_kx_i   (kx_req_valid),
    .force_kx_i (force_kx_s),
    .gnt_kx_o   (gnt_kx_s),
    .gnt_st_o   (gnt_st_s)
  );

  assign sbox_in_s = gnt_kx_s ? kx_req_data : buf_q[idx_q];

  aes_sbox_word u_sbox (
    .word_i (sbox_in_s),
    .word_o (sbox_out_s)
  );

  // FSM next state, block buffer write-back and kx response capture.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    buf_d          = buf_q;
    kx_rsp_valid_d = gnt_kx_s;
    kx_rsp_data_d  = gnt_kx_s ? sbox_out_s : kx_rsp_data_q;
    case (state_q)
      IDLE: begin
        if (st_req_valid) begin
          buf_d   = st_req_data;
          idx_d   = 2'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (gnt_st_s) begin
          buf_d[idx_q] = sbox_out_s;
          idx_d        = idx_q + 2'd1;
          if (idx_q == 2'(NUM_WORDS - 1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        // No new accept here: the request is taken in the following IDLE cycle.
        if (st_rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, buffer and kx response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= 2'd0;
      buf_q          <= {BLOCK_W{1'b0}};
      kx_rsp_valid_q <= 1'b0;
      kx_rsp_data_q  <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      buf_q          <= buf_d;
      kx_rsp_valid_q <= kx_rsp_valid_d;
      kx_rsp_data_q  <= kx_rsp_data_d;
    end
  end

  assign st_req_ready = (state_q == IDLE);
  assign st_rsp_valid = (state_q == DONE);
  assign st_rsp_data  = (state_q == DONE) ? buf_q : {BLOCK_W{1'b0}};
  assign kx_req_ready = gnt_kx_s;
  assign kx_rsp_valid = kx_rsp_valid_q;
  assign kx_rsp_data  = kx_rsp_data_q;
  assign busy         = (state_q != IDLE);

`ifdef AES_SBOX_SCHED_PERF_EN
  logic        stall_s;
  logic [15:0] stall_cnt_q;

  assign stall_s = (kx_req_valid & ~gnt_kx_s) | (req_st_s & ~gnt_st_s);

  // Saturating count of cycles where a valid requester was denied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_aes_sbox_sched.sv
module tb_aes_sbox_sched;

  localparam bit KP = 1'b1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         st_req_valid;
  logic         st_req_ready;
  logic [127:0] st_req_data;
  logic         st_rsp_valid;
  logic         st_rsp_ready;
  logic [127:0] st_rsp_data;
  logic         kx_req_valid;
  logic         kx_req_ready;
  logic [31:0]  kx_req_data;
  logic         kx_rsp_valid;
  logic [31:0]  kx_rsp_data;
  logic         busy;
  logic [15:0]  perf_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_sbox_sched #(.KEY_PRIO(KP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .st_req_valid   (st_req_valid),
    .st_req_ready   (st_req_ready),
    .st_req_data    (st_req_data),
    .st_rsp_valid   (st_rsp_valid),
    .st_rsp_ready   (st_rsp_ready),
    .st_rsp_data    (st_rsp_data),
    .kx_req_valid   (kx_req_valid),
    .kx_req_ready   (kx_req_ready),
    .kx_req_data    (kx_req_data),
    .kx_rsp_valid   (kx_rsp_valid),
    .kx_rsp_data    (kx_rsp_data),
    .busy           (busy),
    .perf_stall_cnt (perf_stall_cnt)
  );

  // ---------------- reference S-box (inverse by search + affine by bit rule)
  function automatic logic [7:0] r_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) r = r ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      bb = bb >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] r_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] c = 8'h63;
    logic [7:0] s;
    for (int y = 1; y < 256; y++)
      if (r_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [31:0] r_word(input logic [31:0] w);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = r_sbox(w[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] r_block(input logic [127:0] b);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = r_sbox(b[8*i +: 8]);
    return o;
  endfunction

  // ---------------- transaction-level model
  int           m_phase;     // 0 idle, 1 serialising, 2 result held
  int           m_served;    // state words substituted so far
  bit           m_turn_kx;   // kx wins the next tie
  logic [127:0] m_res;
  bit           m_pend;
  logic [31:0]  m_kx_last;
  int           m_stall;

  task automatic model_reset();
    m_phase = 0; m_served = 0; m_turn_kx = KP; m_res = '0;
    m_pend = 1'b0; m_kx_last = 32'h0; m_stall = 0;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive at edge+1, check combinational view, advance model, check registered view.
  task automatic cycle(input bit stv, input logic [127:0] std, input bit kxv,
                       input logic [31:0] kxd, input bit rdy);
    bit gkx;
    st_req_valid = stv; st_req_data = std; kx_req_valid = kxv;
    kx_req_data = kxd; st_rsp_ready = rdy;
    #1;
    gkx = kxv && (m_phase != 1 || m_turn_kx);
    chk("kx_req_ready", 128'(kx_req_ready), 128'(gkx));
    chk("st_req_ready", 128'(st_req_ready), 128'(m_phase == 0));
    chk("busy", 128'(busy), 128'(m_phase != 0));
    chk("st_rsp_valid", 128'(st_rsp_valid), 128'(m_phase == 2));
    if (m_phase == 2) chk("st_rsp_data", st_rsp_data, m_res);
`ifdef AES_SBOX_SCHED_PERF_EN
    chk("perf_stall_cnt", 128'(perf_stall_cnt), 128'(m_stall));
`else
    chk("perf_stall_cnt", 128'(perf_stall_cnt), 128'(0));
`endif
    m_pend = gkx;
    if (gkx) m_kx_last = r_word(kxd);
    case (m_phase)
      0: begin
        m_turn_kx = KP;
        if (stv) begin m_res = r_block(std); m_served = 0; m_phase = 1; end
      end
      1: begin
        if (kxv) begin
          if (m_turn_kx) m_turn_kx = 1'b0;
          else begin m_served++; m_turn_kx = 1'b1; end
          if (m_stall < 65535) m_stall++;
        end else m_served++;
        if (m_served == 4) m_phase = 2;
      end
      default: begin
        m_turn_kx = KP;
        if (rdy) m_phase = 0;
      end
    endcase
    @(posedge clk); #1;
    chk("kx_rsp_valid", 128'(kx_rsp_valid), 128'(m_pend));
    chk("kx_rsp_data", 128'(kx_rsp_data), 128'(m_kx_last));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_st_rsp_valid", 128'(st_rsp_valid), 128'(0));
    chk("rst_st_rsp_data", st_rsp_data, 128'(0));
    chk("rst_kx_rsp_valid", 128'(kx_rsp_valid), 128'(0));
    chk("rst_kx_rsp_data", 128'(kx_rsp_data), 128'(0));
    chk("rst_kx_req_ready", 128'(kx_req_ready), 128'(0));
    chk("rst_perf", 128'(perf_stall_cnt), 128'(0));
  endtask

  typedef struct {
    logic [127:0] st;
    bit           kx_hold;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  typedef struct {
    logic [31:0] in;
    logic [31:0] exp;
  } kv_t;

  vec_t vt[3];
  kv_t  kv[3];

  initial begin
    int n;
    vt[0] = '{128'h0, 1'b0, 128'h63636363_63636363_63636363_63636363, 5};
    vt[1] = '{128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b1,
              128'h637C777B_F26B6FC5_3001672B_FED7AB76, 9};
    vt[2] = '{128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b0,
              128'h637C777B_F26B6FC5_3001672B_FED7AB76, 5};
    kv[0] = '{32'h5301FF00, 32'hED7C1663};
    kv[1] = '{32'h10203040, 32'hCAB70409};
    kv[2] = '{32'h01020304, 32'h7C777BF2};

    rst_n = 1'b0; st_req_valid = 1'b0; st_req_data = '0; st_rsp_ready = 1'b0;
    kx_req_valid = 1'b0; kx_req_data = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    chk("rst_st_req_ready", 128'(st_req_ready), 128'(1));
    rst_n = 1'b1;

    // SubWord lookups from IDLE against known constants
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1, kv[i].in, 1'b0);
      chk("kx_tbl_valid", 128'(kx_rsp_valid), 128'(1));
      chk("kx_tbl_data", 128'(kx_rsp_data), 128'(kv[i].exp));
    end
    cycle(1'b0, '0, 1'b0, 32'h0, 1'b0);

    // Block vectors: latency, result, then a long DONE hold with kx traffic
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, vt[i].st, vt[i].kx_hold, $urandom, 1'b0);
      n = 0;
      while (!st_rsp_valid && n < 20) begin
        cycle(1'b0, '0, vt[i].kx_hold, $urandom, 1'b0);
        n++;
      end
      chk("st_latency", 128'(n + 1), 128'(vt[i].lat));
      chk("st_tbl_data", st_rsp_data, vt[i].exp);
      for (int k = 0; k < 10; k++)
        cycle(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, $urandom, 1'b0);
      cycle(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 32'h0, 1'b1);
      chk("no_accept_in_done", 128'(busy), 128'(0));
      cycle(1'b0, '0, 1'b0, 32'h0, 1'b0);
    end

    // Reset while serialising with two words done
    cycle(1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1, 32'hDEADBEEF, 1'b0);
    cycle(1'b0, '0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, '0, 1'b0, 32'h0, 1'b0);
    st_req_valid = 1'b0; kx_req_valid = 1'b0; st_rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) cycle(1'b0, '0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, vt[1].st, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b0, 32'h0, 1'b0);
    chk("post_rst_data", st_rsp_data, vt[1].exp);
    cycle(1'b0, '0, 1'b0, 32'h0, 1'b1);

    // Randomised traffic against the model
    for (int k = 0; k < 1500; k++)
      cycle(($urandom_range(2) == 0), {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(1) == 1, $urandom, $urandom_range(1) == 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
